// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve
// Purpose  : Resolves branch direction/target from comparator flags into a
//            one-entry valid/ready output stage with saturating statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_imm,
    input  logic             i_pred_taken,
    input  logic             i_eq,
    input  logic             i_lt,
    input  logic             i_ltu,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_taken,
    output logic [XLEN-1:0]  o_target,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_mispredict,
    output logic             o_illegal,
    output logic             o_misaligned,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam logic [0:0]       c_EMPTY    = 1'b0;
    localparam logic [0:0]       c_FULL     = 1'b1;
    localparam logic [XLEN-1:0]  c_PC_STEP  = XLEN'(4);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [0:0]       r_state;
    logic             w_accept;
    logic             w_deliver;
    logic             w_taken;
    logic             w_illegal;
    logic [XLEN-1:0]  w_target;

    assign o_valid   = (r_state == c_FULL);
    assign o_ready   = ~i_rst & ~i_flush & ((r_state == c_EMPTY) | i_ready);
    assign w_accept  = i_valid & o_ready;
    assign w_deliver = o_valid & i_ready;
    assign w_target  = i_pc + i_imm;

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (i_funct3)
            3'b000:  w_taken = i_eq;
            3'b001:  w_taken = ~i_eq;
            3'b100:  w_taken = i_lt;
            3'b101:  w_taken = ~i_lt;
            3'b110:  w_taken = i_ltu;
            3'b111:  w_taken = ~i_ltu;
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= c_EMPTY;
            o_taken       <= 1'b0;
            o_target      <= '0;
            o_redirect_pc <= '0;
            o_mispredict  <= 1'b0;
            o_illegal     <= 1'b0;
            o_misaligned  <= 1'b0;
            o_branch_cnt  <= '0;
            o_mispred_cnt <= '0;
        end else begin
            // A delivery counts even when a flush lands in the same cycle.
            if (w_deliver && !o_illegal) begin
                if (!(&o_branch_cnt)) begin
                    o_branch_cnt <= o_branch_cnt + c_CNT_ONE;
                end
                if (o_mispredict && !(&o_mispred_cnt)) begin
                    o_mispred_cnt <= o_mispred_cnt + c_CNT_ONE;
                end
            end

            if (i_flush) begin
                r_state <= c_EMPTY;
            end else if (w_accept) begin
                r_state       <= c_FULL;
                o_taken       <= w_taken;
                o_target      <= w_target;
                o_redirect_pc <= w_taken ? w_target : (i_pc + c_PC_STEP);
                o_mispredict  <= ~w_illegal & (w_taken ^ i_pred_taken);
                o_illegal     <= w_illegal;
                o_misaligned  <= w_taken & (w_target[1:0] != 2'b00);
            end else if (w_deliver) begin
                r_state <= c_EMPTY;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution stage directly downstream of the integer comparator. Consumes the comparator's equal, signed less-than and unsigned less-than flags, together with the branch's funct3, PC, immediate and predicted direction. Registers the resolved direction, target, redirect PC and mispredict flag into a one-entry output stage with valid/ready handshakes on both sides. Also maintains saturating counters of resolved branches and mispredicts.

## Interface
- XLEN, 32, width of PC, immediate and target
- CNT_W, 32, width of the statistics counters
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  reset: one clock, synchronous and active-high
- i_valid  input  1  upstream request valid
- o_ready  output  1  stage can accept a request this cycle
- i_funct3  input  3  RV32I branch funct3
- i_pc  input  XLEN  branch instruction PC
- i_imm  input  XLEN  sign-extended B-type immediate
- i_pred_taken  input  1  front-end predicted direction
- i_eq  input  1  comparator flag: op1 == op2
- i_lt  input  1  comparator flag: op1 < op2, signed
- i_ltu  input  1  comparator flag: op1 < op2, unsigned
- i_flush  input  1  kill the held entry and block acceptance this cycle
- o_valid  output  1  resolved result valid
- i_ready  input  1  downstream accepts the result
- o_taken  output  1  resolved direction
- o_target  output  XLEN  pc + imm
- o_redirect_pc  output  XLEN  next PC: o_target if taken, else pc + 4
- o_mispredict  output  1  o_taken != predicted direction
- o_illegal  output  1  funct3 is 010 or 011
- o_misaligned  output  1  taken and o_target[1:0] != 0
- o_branch_cnt  output  CNT_W  resolved legal branches delivered
- o_mispred_cnt  output  CNT_W  mispredicted legal branches delivered

## Operation
- Two states.
  - EMPTY: o_valid = 0.
  - FULL: o_valid = 1, outputs are the held result.
- o_ready = ~i_rst & ~i_flush & (EMPTY | i_ready).
- Accept: i_valid & o_ready. Next state is FULL, and all result outputs load from the current inputs.
- Deliver: o_valid & i_ready. Next state is EMPTY, unless an accept happens in the same cycle; then the state stays FULL with the new result.
- Direction decode:
  - 000 BEQ: eq
  - 001 BNE: ~eq
  - 100 BLT: lt
  - 101 BGE: ~lt
  - 110 BLTU: ltu
  - 111 BGEU: ~ltu
  - 010 / 011: illegal, with taken = 0, mispredict = 0, misaligned = 0, illegal = 1.
- Address arithmetic:
  - target = (pc + imm) mod 2^XLEN.
  - pc + 4 also wraps mod 2^XLEN.
  - The carry out of either sum is discarded.
- Mispredict for legal ops: taken XOR i_pred_taken.
- Counters:
  - Update only on deliver of a legal entry.
  - branch_cnt increments by 1.
  - mispred_cnt increments by 1 when o_mispredict is 1.
  - Both saturate at all-ones and never wrap.
- Flush:
  - Next state is EMPTY regardless of i_ready.
  - No accept that cycle.
  - A deliver coinciding with flush still counts. The entry was already consumed.
- Outputs hold stable while FULL and ~i_ready.

## Timing
- Latency: 1 cycle from accept to o_valid.
- Throughput: 1 branch per cycle while i_ready = 1.
- o_ready is combinational from state, i_ready, i_flush and i_rst. There is no path from i_valid to o_ready.
- Comparator flags and request fields are sampled only in the accept cycle.
- Reset values:
  - State EMPTY.
  - o_valid, o_taken, o_mispredict, o_illegal, o_misaligned all 0.
  - o_target = 0, o_redirect_pc = 0.
  - Both counters 0.
  - o_ready = 0 while i_rst is high.
- Reset mid-operation: a held entry is discarded without delivery and is not counted.
- Reset dominates flush. Flush dominates accept.

## Test plan
- Reset, then BEQ: pc = 0x100, imm = 0x20, eq = 1, pred = 0.
  - Next cycle: o_valid = 1, taken = 1, target = 0x120, redirect = 0x120, mispredict = 1.
  - After deliver: branch_cnt = 1, mispred_cnt = 1.
- Back-to-back BLT (lt = 0, pred = 0) then BGEU (ltu = 0, pred = 1), with i_ready held 1.
  - Two consecutive results, both mispredict = 0.
  - The first redirects to pc + 4.
  - o_ready stays 1.
- Backpressure: entry FULL with i_ready = 0 for 3 cycles while i_valid = 1.
  - o_ready = 0.
  - Outputs are unchanged.
  - When i_ready rises, deliver and accept happen in the same cycle.
- Wrap and alignment:
  - pc = 0xFFFFFFFC, imm = 0x8, BNE with eq = 0: target = 0x00000004, redirect = 0x00000004.
  - Separately, imm = 0x2 taken: misaligned = 1.
- funct3 = 010 with pred = 1: illegal = 1, taken = 0, mispredict = 0, counters unchanged after deliver.
- Flush and saturation:
  - Flush while FULL with i_ready = 0: o_valid = 0 next cycle, counters unchanged, a concurrent i_valid is not accepted.
  - Counters preset near max with CNT_W = 4: holds at 0xF.
